ps2_key_decoder: RTL and testbench
==================================

Name: ps2_key_decoder

Overview:
- Sits directly downstream of the PS/2 keyboard receiver.
- Consumes the receiver's 8-bit scan-code byte stream (`data_out`/`data_valid`) and parses Set-2 prefixes: E0 for extended keys, F0 for break.
- Maintains held/released state for the two players' control keys and feeds the game logic.
- Also emits a one-cycle event pulse for every recognised make or break.

Parameters:
- TIMEOUT_CYCLES, 2500000, clk cycles a prefix state may wait for its next byte before abandoning it (100 ms at 25 MHz). Used only with PREFIX_TIMEOUT_EN.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous reset, active-low
- code_in  input  8  scan-code byte from the PS/2 receiver
- code_valid  input  1  single-cycle strobe; code_in is valid this cycle
- p1_keys  output  5  player 1 held keys {bomb,right,left,down,up}
- p2_keys  output  5  player 2 held keys {bomb,right,left,down,up}
- key_event  output  1  one-cycle pulse: a recognised key changed state
- key_id  output  4  0-4 = p1 up,down,left,right,bomb; 5-9 = p2 same order; valid with key_event
- key_release  output  1  1 = break, 0 = make; valid with key_event

Behaviour:
- Reset (async, reset_n=0): p1_keys=0, p2_keys=0, key_event=0, key_id=0, key_release=0, FSM=IDLE, timeout counter=0.
- Key map (Set 2):
  - P1: W=1D up, S=1B down, A=1C left, D=23 right, Space=29 bomb. Non-extended only.
  - P2: E0 75 up, E0 72 down, E0 6B left, E0 74 right, 5A (main Enter) bomb.
  - Extended match requires the E0 prefix; non-extended match requires its absence. So keypad 8 (75) and keypad Enter (E0 5A) do not match.
- The FSM advances only on cycles with code_valid=1.
  - IDLE: E0 -> EXT; F0 -> BRK; 00 or FF -> FLUSH action; other -> apply make (ext=0), stay IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> EXT; 00/FF -> FLUSH; other -> apply make (ext=1), -> IDLE.
  - BRK: E0 -> EXT_BRK; F0 -> BRK; 00/FF -> FLUSH; other -> apply break (ext=0), -> IDLE.
  - EXT_BRK: E0/F0 -> stay; 00/FF -> FLUSH; other -> apply break (ext=1), -> IDLE.
- FSM encoding: states IDLE, EXT, BRK, EXT_BRK.
- Apply, matched key:
  - Make sets its bit; break clears its bit.
  - key_event=1, key_id and key_release driven. All three are registered, one clk after the code_valid cycle.
- Apply, unmatched code: no key bit changes, no key_event. Codes AA, FA, EE, E1 and Pause fragments are therefore ignored.
- Repeated make (typematic): bit stays 1, but key_event still pulses with key_release=0. Consumers must edge-detect if needed.
- Break of a key not held: bit stays 0; key_event still pulses with key_release=1.
- FLUSH (keyboard overrun code 00 or FF): all p1_keys/p2_keys cleared in the next cycle, FSM -> IDLE, no key_event.
- key_event is a single-cycle pulse even when code_valid arrives on consecutive cycles; each valid byte is handled independently.
- Reset asserted mid-sequence (e.g. after E0, before the code): all state cleared; the next byte is parsed from IDLE.
- Opposing directions held simultaneously are both reported; arbitration belongs to the game logic.

Optional Feature:
- Macro: PREFIX_TIMEOUT_EN.
- When defined:
  - A counter runs while the FSM is in EXT, BRK or EXT_BRK; it is cleared on every code_valid and in IDLE.
  - On reaching TIMEOUT_CYCLES-1 the FSM returns to IDLE without applying anything. Key bits and key_event are unchanged.
  - Counter width is $clog2(TIMEOUT_CYCLES).
- When undefined: no counter. A prefix state waits indefinitely for the next byte.

Test Plan:
- Byte 1D -> p1_keys=00001 one clk later; key_event=1, key_id=0, key_release=0. Then F0,1D -> p1_keys=00000, key_event with key_id=0, key_release=1.
- E0,75 then E0,6B -> p2_keys=00101; key_ids 5 then 7. Then E0,F0,75 -> p2_keys=00100, key_id=5, key_release=1.
- Byte 75 without prefix (keypad 8) and E0,5A (keypad Enter) -> p2_keys unchanged, no key_event. Byte 5A -> p2_keys bit4=1, key_id=9.
- Hold 29 (Space), 1C (A), E0 74 -> p1_keys=10100, p2_keys=01000. Then byte 00 -> both vectors 0, no key_event, following byte 1B parsed as make of key_id=1.
- Sequence E0, then reset_n pulse low, then 75 -> p2_keys=0, no event (non-extended 75 unmatched). Back-to-back code_valid 1D,23 on consecutive cycles -> two key_event pulses, p1_keys=01001.
- With PREFIX_TIMEOUT_EN and TIMEOUT_CYCLES=16: F0, wait 20 clk, then 1D -> treated as make, p1_keys bit0=1. Without the macro, the same stimulus is a break and p1_keys bit0 stays 0.

Source files
------------

// File: rtl/ps2_key_decoder.sv
// PS/2 Set-2 scan-code decoder: tracks two players' held keys and pulses an event per make/break.
// Optional build macro PREFIX_TIMEOUT_EN abandons a stale E0/F0 prefix after TIMEOUT_CYCLES clocks.
module ps2_key_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 2500000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] code_in,
    input  logic       code_valid,
    output logic [4:0] p1_keys,
    output logic [4:0] p2_keys,
    output logic       key_event,
    output logic [3:0] key_id,
    output logic       key_release
);

    typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} state_e;

    state_e     state_q;
    logic [9:0] keys_q;

    logic       ext_flag;
    logic       brk_flag;
    logic       hit;
    logic       ext_need;
    logic [3:0] id;
    logic       match;

    always_comb begin
        ext_flag = (state_q == StExt) || (state_q == StExtBrk);
        brk_flag = (state_q == StBrk) || (state_q == StExtBrk);
        {hit, ext_need, id} = {1'b1, 1'b0, 4'd0};
        case (code_in)
            8'h1D:   {hit, ext_need, id} = {1'b1, 1'b0, 4'd0};
            8'h1B:   {hit, ext_need, id} = {1'b1, 1'b0, 4'd1};
            8'h1C:   {hit, ext_need, id} = {1'b1, 1'b0, 4'd2};
            8'h23:   {hit, ext_need, id} = {1'b1, 1'b0, 4'd3};
            8'h29:   {hit, ext_need, id} = {1'b1, 1'b0, 4'd4};
            8'h75:   {hit, ext_need, id} = {1'b1, 1'b1, 4'd5};
            8'h72:   {hit, ext_need, id} = {1'b1, 1'b1, 4'd6};
            8'h6B:   {hit, ext_need, id} = {1'b1, 1'b1, 4'd7};
            8'h74:   {hit, ext_need, id} = {1'b1, 1'b1, 4'd8};
            8'h5A:   {hit, ext_need, id} = {1'b1, 1'b0, 4'd9};
            default: {hit, ext_need, id} = {1'b0, 1'b0, 4'd0};
        endcase
        // Keypad 8 (bare 75) and keypad Enter (E0 5A) must not alias the game keys.
        match = hit && (ext_need == ext_flag);
    end

`ifdef PREFIX_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
    logic [CntW-1:0] tmo_cnt_q;
`else
    // Keep the parameter referenced when the timeout is compiled out.
    localparam int unsigned unused_timeout = TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            keys_q      <= '0;
            key_event   <= 1'b0;
            key_id      <= '0;
            key_release <= 1'b0;
`ifdef PREFIX_TIMEOUT_EN
            tmo_cnt_q   <= '0;
`endif
        end else begin
            key_event <= 1'b0;
            if (code_valid) begin
`ifdef PREFIX_TIMEOUT_EN
                tmo_cnt_q <= '0;
`endif
                if (code_in == 8'hE0) begin
                    state_q <= brk_flag ? StExtBrk : StExt;
                end else if (code_in == 8'hF0) begin
                    state_q <= ext_flag ? StExtBrk : StBrk;
                end else begin
                    state_q <= StIdle;
                    if (code_in == 8'h00 || code_in == 8'hFF) begin
                        keys_q <= '0;
                    end else if (match) begin
                        keys_q[id]  <= ~brk_flag;
                        key_event   <= 1'b1;
                        key_id      <= id;
                        key_release <= brk_flag;
                    end
                end
            end
`ifdef PREFIX_TIMEOUT_EN
            else if (state_q == StIdle) begin
                tmo_cnt_q <= '0;
            end else if (tmo_cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                state_q   <= StIdle;
                tmo_cnt_q <= '0;
            end else begin
                tmo_cnt_q <= tmo_cnt_q + CntW'(1);
            end
`endif
        end
    end

    assign p1_keys = keys_q[4:0];
    assign p2_keys = keys_q[9:5];

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed vector table, hand-written corner sequences and
// randomized bytes checked against a prefix-queue reference model.
module tb_ps2_key_decoder;

    localparam int unsigned Tmo = 16;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] code_in;
    logic       code_valid;
    logic [4:0] p1_keys;
    logic [4:0] p2_keys;
    logic       key_event;
    logic [3:0] key_id;
    logic       key_release;

    ps2_key_decoder #(.TIMEOUT_CYCLES(Tmo)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .code_in    (code_in),
        .code_valid (code_valid),
        .p1_keys    (p1_keys),
        .p2_keys    (p2_keys),
        .key_event  (key_event),
        .key_id     (key_id),
        .key_release(key_release)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    endtask

    // Reference model: pending prefixes kept as a list, keys as a 10-bit held vector.
    logic [7:0] key_codes [10] = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h29,
                                   8'h75, 8'h72, 8'h6B, 8'h74, 8'h5A};
    logic [7:0] pend[$];
    logic [9:0] m_keys = '0;
    bit         m_ev;
    int         m_id;
    bit         m_rel;
    int         gap = 0;

    task automatic model_reset();
        pend.delete();
        m_keys = '0;
        m_ev   = 1'b0;
        gap    = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        bit ext = 1'b0;
        bit brk = 1'b0;
`ifdef PREFIX_TIMEOUT_EN
        if (gap >= int'(Tmo)) pend.delete();
`endif
        gap  = 0;
        m_ev = 1'b0;
        if (b == 8'hE0 || b == 8'hF0) begin
            pend.push_back(b);
        end else if (b == 8'h00 || b == 8'hFF) begin
            m_keys = '0;
            pend.delete();
        end else begin
            foreach (pend[i]) begin
                if (pend[i] == 8'hE0) ext = 1'b1;
                if (pend[i] == 8'hF0) brk = 1'b1;
            end
            for (int i = 0; i < 10; i++) begin
                if (key_codes[i] == b && ((i >= 5 && i <= 8) == ext)) begin
                    m_keys[i] = ~brk;
                    m_ev  = 1'b1;
                    m_id  = i;
                    m_rel = brk;
                end
            end
            pend.delete();
        end
    endtask

    // Drive one byte for one cycle; returns at posedge+1 with outputs updated.
    task automatic send(input logic [7:0] b);
        code_in    = b;
        code_valid = 1'b1;
        model_byte(b);
        @(posedge clk);
        #1;
        code_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            gap++;
        end
        m_ev = 1'b0;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " p1_keys"}, int'(p1_keys), int'(m_keys[4:0]));
        chk({tag, " p2_keys"}, int'(p2_keys), int'(m_keys[9:5]));
        chk({tag, " key_event"}, int'(key_event), int'(m_ev));
        if (m_ev) begin
            chk({tag, " key_id"}, int'(key_id), m_id);
            chk({tag, " key_release"}, int'(key_release), int'(m_rel));
        end
    endtask

    typedef struct {
        logic [7:0] code;
        logic [4:0] p1;
        logic [4:0] p2;
        bit         ev;
        logic [3:0] id;
        bit         rel;
    } vec_t;

    function automatic vec_t mk(logic [7:0] c, logic [4:0] p1, logic [4:0] p2, bit ev,
                                logic [3:0] id, bit rel);
        vec_t v;
        v.code = c; v.p1 = p1; v.p2 = p2; v.ev = ev; v.id = id; v.rel = rel;
        return v;
    endfunction

    vec_t vecs[$];
    logic [7:0] pool [14] = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h29, 8'h75, 8'h72,
                              8'h6B, 8'h74, 8'h5A, 8'hE0, 8'hF0, 8'hE0, 8'hF0};

    initial begin
        vecs.push_back(mk(8'h1D, 5'b00001, 5'b00000, 1, 0, 0));
        vecs.push_back(mk(8'hF0, 5'b00001, 5'b00000, 0, 0, 0));
        vecs.push_back(mk(8'h1D, 5'b00000, 5'b00000, 1, 0, 1));
        vecs.push_back(mk(8'hE0, 5'b00000, 5'b00000, 0, 0, 0));
        vecs.push_back(mk(8'h75, 5'b00000, 5'b00001, 1, 5, 0));
        vecs.push_back(mk(8'hE0, 5'b00000, 5'b00001, 0, 0, 0));
        vecs.push_back(mk(8'h6B, 5'b00000, 5'b00101, 1, 7, 0));
        vecs.push_back(mk(8'hE0, 5'b00000, 5'b00101, 0, 0, 0));
        vecs.push_back(mk(8'hF0, 5'b00000, 5'b00101, 0, 0, 0));
        vecs.push_back(mk(8'h75, 5'b00000, 5'b00100, 1, 5, 1));
        vecs.push_back(mk(8'h75, 5'b00000, 5'b00100, 0, 0, 0));
        vecs.push_back(mk(8'hE0, 5'b00000, 5'b00100, 0, 0, 0));
        vecs.push_back(mk(8'h5A, 5'b00000, 5'b00100, 0, 0, 0));
        vecs.push_back(mk(8'h5A, 5'b00000, 5'b10100, 1, 9, 0));
        vecs.push_back(mk(8'h00, 5'b00000, 5'b00000, 0, 0, 0));
        vecs.push_back(mk(8'h29, 5'b10000, 5'b00000, 1, 4, 0));
        vecs.push_back(mk(8'h1C, 5'b10100, 5'b00000, 1, 2, 0));
        vecs.push_back(mk(8'hE0, 5'b10100, 5'b00000, 0, 0, 0));
        vecs.push_back(mk(8'h74, 5'b10100, 5'b01000, 1, 8, 0));
        vecs.push_back(mk(8'h00, 5'b00000, 5'b00000, 0, 0, 0));
        vecs.push_back(mk(8'h1B, 5'b00010, 5'b00000, 1, 1, 0));
        vecs.push_back(mk(8'hF0, 5'b00010, 5'b00000, 0, 0, 0));
        vecs.push_back(mk(8'h1B, 5'b00000, 5'b00000, 1, 1, 1));
        vecs.push_back(mk(8'hF0, 5'b00000, 5'b00000, 0, 0, 0));
        vecs.push_back(mk(8'h23, 5'b00000, 5'b00000, 1, 3, 1));
        vecs.push_back(mk(8'h1D, 5'b00001, 5'b00000, 1, 0, 0));
        vecs.push_back(mk(8'h1D, 5'b00001, 5'b00000, 1, 0, 0));
        vecs.push_back(mk(8'hAA, 5'b00001, 5'b00000, 0, 0, 0));
        vecs.push_back(mk(8'hFF, 5'b00000, 5'b00000, 0, 0, 0));

        reset_n    = 1'b0;
        code_in    = 8'h00;
        code_valid = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset p1_keys", int'(p1_keys), 0);
        chk("reset p2_keys", int'(p2_keys), 0);
        chk("reset key_event", int'(key_event), 0);
        chk("reset key_id", int'(key_id), 0);
        chk("reset key_release", int'(key_release), 0);
        reset_n = 1'b1;
        idle(2);

        // Directed table, bytes on consecutive cycles.
        foreach (vecs[i]) begin
            send(vecs[i].code);
            chk($sformatf("vec%0d p1_keys", i), int'(p1_keys), int'(vecs[i].p1));
            chk($sformatf("vec%0d p2_keys", i), int'(p2_keys), int'(vecs[i].p2));
            chk($sformatf("vec%0d key_event", i), int'(key_event), int'(vecs[i].ev));
            if (vecs[i].ev) begin
                chk($sformatf("vec%0d key_id", i), int'(key_id), int'(vecs[i].id));
                chk($sformatf("vec%0d key_release", i), int'(key_release), int'(vecs[i].rel));
            end
        end

        // Reset between E0 and its code: 75 must then parse as a bare (unmatched) byte.
        send(8'h1D);
        send(8'hE0);
        reset_n = 1'b0;
        model_reset();
        idle(2);
        chk("midreset p1_keys", int'(p1_keys), 0);
        chk("midreset key_event", int'(key_event), 0);
        reset_n = 1'b1;
        idle(1);
        send(8'h75);
        chk("midreset p2_keys", int'(p2_keys), 0);
        chk("midreset 75 key_event", int'(key_event), 0);

        // Back-to-back makes give two separate pulses, then the pulse drops.
        send(8'h1D);
        chk("b2b first key_event", int'(key_event), 1);
        send(8'h23);
        chk("b2b second key_event", int'(key_event), 1);
        chk("b2b second key_id", int'(key_id), 3);
        chk("b2b p1_keys", int'(p1_keys), 5'b01001);
        idle(1);
        chk("b2b pulse drop", int'(key_event), 0);

        // Stale F0 prefix: a timeout turns the following 1D into a make.
        send(8'hFF);
        send(8'hF0);
        idle(20);
        send(8'h1D);
`ifdef PREFIX_TIMEOUT_EN
        chk("timeout p1_keys", int'(p1_keys), 5'b00001);
        chk("timeout key_release", int'(key_release), 0);
`else
        chk("no-timeout p1_keys", int'(p1_keys), 5'b00000);
        chk("no-timeout key_release", int'(key_release), 1);
`endif
        chk("timeout key_event", int'(key_event), 1);

        // Randomized bytes against the reference model.
        send(8'hFF);
        for (int n = 0; n < 600; n++) begin
            int sel = int'($urandom_range(0, 19));
            logic [7:0] b;
            if (sel < 14) b = pool[sel];
            else if (sel == 14) b = 8'h00;
            else b = 8'($urandom_range(0, 255));
            send(b);
            chk_model($sformatf("rnd%0d(%02h)", n, b));
            if ($urandom_range(0, 3) == 0) begin
                idle(int'($urandom_range(1, 3)));
                chk_model($sformatf("rnd%0d idle", n));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
